// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch program counter for the RV32I front end.
//
// Generalises a fixed PC+4 adder. The PC width, sequential step and target
// alignment are parameters. The block adds a valid/ready fetch handshake,
// stall hold, redirects (deferred while a fetch is in flight), an epoch tag
// for stale-fetch filtering, and misaligned-target trapping.
//
// Ports
//   clk            : single clock, all state on the rising edge
//   rst            : synchronous, active-high reset
//   FetchReady     : instruction memory accepts the presented PC
//   Stall          : pipeline hazard, blocks the sequential advance
//   RedirectValid  : redirect request, sampled every cycle
//   RedirectTarget : redirect address
//   PCOutput       : current fetch PC
//   PCPlusStep     : PCOutput + STEP (combinational, wraps mod 2^XLEN)
//   FetchValid     : PCOutput is a live fetch request
//   FetchEpoch     : tag for PCOutput, toggles on every applied redirect
//   MisalignValid  : misaligned redirect target trap
//   MisalignAddr   : offending target
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one cycle after reset, no fetch; a redirect may load the PC
// RUN   | fetching; advance, hold, or apply a direct/pending redirect
// TRAP  | misaligned target seen; fetch stopped until an aligned redirect

module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter int               STEP         = 4,
    parameter int               ALIGN_BITS   = 2,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FetchReady,
    input  logic            Stall,
    input  logic            RedirectValid,
    input  logic [XLEN-1:0] RedirectTarget,
    output logic [XLEN-1:0] PCOutput,
    output logic [XLEN-1:0] PCPlusStep,
    output logic            FetchValid,
    output logic            FetchEpoch,
    output logic            MisalignValid,
    output logic [XLEN-1:0] MisalignAddr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : g_bad_reset_vector
        $error("pc_sequencer: RESET_VECTOR is not aligned to ALIGN_BITS");
    end

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

    logic [XLEN-1:0] pc_plus;
    logic            load_valid;
    logic [XLEN-1:0] load_tgt;

    assign pc_plus = pc_q + XLEN'(STEP);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        mis_addr_d = mis_addr_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        load_valid = 1'b0;
        load_tgt   = RedirectTarget;

        unique case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                load_valid = RedirectValid;
            end
            ST_RUN: begin
                // FetchValid is always 1 here, so FetchReady alone tells
                // in-flight (0) from handshake completion (1).
                if (!FetchReady) begin
                    if (RedirectValid) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = RedirectTarget;
                    end
                end else if (RedirectValid) begin
                    // A fresh redirect in the completion cycle beats the pending one.
                    load_valid = 1'b1;
                    pend_d     = 1'b0;
                end else if (pend_q) begin
                    // Pending redirect lands on completion even under Stall.
                    load_valid = 1'b1;
                    load_tgt   = pend_tgt_q;
                    pend_d     = 1'b0;
                end else if (!Stall) begin
                    pc_d = pc_plus;
                end
            end
            ST_TRAP: begin
                load_valid = RedirectValid;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Alignment is only judged at the moment a target would load the PC.
        if (load_valid) begin
            if ((load_tgt & ALIGN_MASK) != '0) begin
                state_d    = ST_TRAP;
                mis_addr_d = load_tgt;
            end else begin
                state_d = ST_RUN;
                pc_d    = load_tgt;
                epoch_d = ~epoch_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epoch_q    <= 1'b0;
            mis_addr_q <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            mis_addr_q <= mis_addr_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign PCOutput      = pc_q;
    assign PCPlusStep    = pc_plus;
    assign FetchValid    = (state_q == ST_RUN);
    assign FetchEpoch    = epoch_q;
    assign MisalignValid = (state_q == ST_TRAP);
    assign MisalignAddr  = mis_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: u0 uses ALIGN_BITS=2, u1 uses ALIGN_BITS=1.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp;
        logic        fv;
        logic        ep;
        logic        mv;
        logic [31:0] ma;
    } obs_t;

    typedef struct packed {
        bit          rst;
        bit          fr;
        bit          st;
        bit          rv;
        logic [31:0] tgt;
        obs_t        exp;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, fr0 = 1'b1, st0 = 1'b0, rv0 = 1'b0;
    logic [31:0] tgt0 = '0;
    logic [31:0] pc0, pcp0, ma0;
    logic        fv0, ep0, mv0;

    logic        rst1 = 1'b1, fr1 = 1'b1, st1 = 1'b0, rv1 = 1'b0;
    logic [31:0] tgt1 = '0;
    logic [31:0] pc1, pcp1, ma1;
    logic        fv1, ep1, mv1;

    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];

    pc_sequencer #(.XLEN(32), .STEP(4), .ALIGN_BITS(2), .RESET_VECTOR(32'h0)) u0 (
        .clk(clk), .rst(rst0), .FetchReady(fr0), .Stall(st0),
        .RedirectValid(rv0), .RedirectTarget(tgt0),
        .PCOutput(pc0), .PCPlusStep(pcp0), .FetchValid(fv0), .FetchEpoch(ep0),
        .MisalignValid(mv0), .MisalignAddr(ma0)
    );

    pc_sequencer #(.XLEN(32), .STEP(4), .ALIGN_BITS(1), .RESET_VECTOR(32'h0)) u1 (
        .clk(clk), .rst(rst1), .FetchReady(fr1), .Stall(st1),
        .RedirectValid(rv1), .RedirectTarget(tgt1),
        .PCOutput(pc1), .PCPlusStep(pcp1), .FetchValid(fv1), .FetchEpoch(ep1),
        .MisalignValid(mv1), .MisalignAddr(ma1)
    );

    function automatic row_t mk(input bit rst, input bit fr, input bit st, input bit rv,
                                input logic [31:0] tgt, input logic [31:0] pc,
                                input bit fv, input bit ep, input bit mv,
                                input logic [31:0] ma);
        row_t r;
        r.rst = rst; r.fr = fr; r.st = st; r.rv = rv; r.tgt = tgt;
        r.exp.pc  = pc;
        r.exp.pcp = pc + 32'd4;
        r.exp.fv  = fv;
        r.exp.ep  = ep;
        r.exp.mv  = mv;
        r.exp.ma  = ma;
        return r;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h pcp=%h fv=%b ep=%b mv=%b ma=%h", o.pc, o.pcp, o.fv, o.ep, o.mv, o.ma);
    endfunction

    function automatic obs_t obs0();
        obs_t o;
        o.pc = pc0; o.pcp = pcp0; o.fv = fv0; o.ep = ep0; o.mv = mv0; o.ma = ma0;
        return o;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.pc = pc1; o.pcp = pcp1; o.fv = fv1; o.ep = ep1; o.mv = mv1; o.ma = ma1;
        return o;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic drive_row(input row_t r, input bit sel);
        if (sel == 1'b0) begin
            rst0 = r.rst; fr0 = r.fr; st0 = r.st; rv0 = r.rv; tgt0 = r.tgt;
        end else begin
            rst1 = r.rst; fr1 = r.fr; st1 = r.st; rv1 = r.rv; tgt1 = r.tgt;
        end
        exp_q.push_back(r.exp);
    endtask

    task automatic test_reset();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0, 32'h4, 1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0, 32'h8, 1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0, 32'hC, 1, 0, 0, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(0, 1, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,         1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,         32'h4,         1, 1, 0, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(0, 1, 0, 1, 32'h20,  32'h20,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 1, 0, 32'h0,   32'h20,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 1, 0, 32'h0,   32'h20,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 1, 0, 32'h0,   32'h20,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 1, 1, 32'h100, 32'h100, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h104, 1, 1, 0, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_inflight();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(0, 1, 0, 1, 32'h40,  32'h40,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 0, 32'h0,   32'h40,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 1, 32'h200, 32'h40,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 1, 32'h300, 32'h40,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 0, 32'h0,   32'h40,  1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h300, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h304, 1, 1, 0, 32'h0));
        // redirect in the completion cycle beats the pending one
        rows.push_back(mk(0, 0, 0, 1, 32'h500, 32'h304, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 1, 32'h600, 32'h600, 1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h604, 1, 0, 0, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL inflight[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_misalign();
        row_t rows[$];
        obs_t got, exp;
        // pending misaligned target traps at completion, even with Stall=1
        rows.push_back(mk(0, 0, 0, 1, 32'h702, 32'h604, 1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 1, 0, 32'h0,   32'h604, 0, 0, 1, 32'h702));
        rows.push_back(mk(0, 1, 0, 1, 32'h400, 32'h400, 1, 1, 0, 32'h702));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h404, 1, 1, 0, 32'h702));
        rows.push_back(mk(0, 1, 0, 1, 32'h102, 32'h404, 0, 1, 1, 32'h102));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h404, 0, 1, 1, 32'h102));
        rows.push_back(mk(0, 1, 0, 1, 32'h106, 32'h404, 0, 1, 1, 32'h106));
        rows.push_back(mk(0, 1, 0, 1, 32'h500, 32'h500, 1, 0, 0, 32'h106));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL misalign[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_pending();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(0, 1, 0, 1, 32'h440, 32'h440, 1, 1, 0, 32'h106));
        rows.push_back(mk(0, 0, 0, 1, 32'h800, 32'h440, 1, 1, 0, 32'h106));
        rows.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h4,   1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h8,   1, 0, 0, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_pending[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_boot_redirect();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 1, 32'h80, 32'h80, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,  32'h84, 1, 1, 0, 32'h0));
        rows.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 1, 32'h82, 32'h0,  0, 0, 1, 32'h82));
        rows.push_back(mk(0, 1, 0, 1, 32'h0,  32'h0,  1, 1, 0, 32'h82));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,  32'h4,  1, 1, 0, 32'h82));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b0);
            @(posedge clk); #1;
            got = obs0();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL boot_redirect[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_align1();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 1, 32'h102, 32'h102, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 0, 32'h0,   32'h106, 1, 1, 0, 32'h0));
        rows.push_back(mk(0, 1, 0, 1, 32'h103, 32'h106, 0, 1, 1, 32'h103));
        rows.push_back(mk(0, 1, 0, 1, 32'h200, 32'h200, 1, 0, 0, 32'h103));
        foreach (rows[i]) begin
            drive_row(rows[i], 1'b1);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL align1[%0d] got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap();
        test_stall();
        test_inflight();
        test_misalign();
        test_reset_pending();
        test_boot_redirect();
        test_align1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
